// File: rtl/ifu_fetch_queue_if.sv
// Fetch-stage bus bundle: PC register, icache and decode signals of ifu_fetch_queue.
// Optional perf counter outputs appear only when IFU_PERF_CNT_EN is defined.
interface ifu_fetch_queue_if #(
  parameter int PC_W   = 32,
  parameter int INST_W = 32
);
  logic [PC_W-1:0]   pc_i;
  logic              pc_req_i;
  logic              flush_i;
  logic              fetch_stall_o;
  logic              is_compressed_o;
  logic              icache_req_valid_o;
  logic              icache_req_ready_i;
  logic [PC_W-1:0]   icache_req_addr_o;
  logic              icache_resp_valid_i;
  logic [INST_W-1:0] icache_resp_data_i;
  logic              dec_valid_o;
  logic              dec_ready_i;
  logic [INST_W-1:0] dec_inst_o;
  logic [PC_W-1:0]   dec_pc_o;
  logic              dec_compressed_o;
`ifdef IFU_PERF_CNT_EN
  logic [63:0]       perf_fetch_cnt_o;
  logic [63:0]       perf_drop_cnt_o;
`endif

  modport slave (
    input  pc_i, pc_req_i, flush_i, icache_req_ready_i,
           icache_resp_valid_i, icache_resp_data_i, dec_ready_i,
    output fetch_stall_o, is_compressed_o, icache_req_valid_o,
           icache_req_addr_o, dec_valid_o, dec_inst_o, dec_pc_o, dec_compressed_o
`ifdef IFU_PERF_CNT_EN
    , output perf_fetch_cnt_o, perf_drop_cnt_o
`endif
  );

  modport master (
    output pc_i, pc_req_i, flush_i, icache_req_ready_i,
           icache_resp_valid_i, icache_resp_data_i, dec_ready_i,
    input  fetch_stall_o, is_compressed_o, icache_req_valid_o,
           icache_req_addr_o, dec_valid_o, dec_inst_o, dec_pc_o, dec_compressed_o
`ifdef IFU_PERF_CNT_EN
    , input perf_fetch_cnt_o, perf_drop_cnt_o
`endif
  );
endinterface

// File: rtl/ifu_fetch_queue.sv
// Instruction fetch stage: one outstanding icache read, registered FIFO toward decode.
// Define IFU_PERF_CNT_EN to add the fetch/drop performance counters.
module ifu_fetch_queue #(
  parameter int PC_W   = 32,
  parameter int INST_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  ifu_fetch_queue_if.slave  bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, WAIT_RESP, DROP} state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic [INST_W-1:0] r_inst [DEPTH];
  logic [PC_W-1:0]   r_pc   [DEPTH];
  logic              r_comp [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_entries;

  logic [CNT_W-1:0]  w_count;
  logic              w_req_valid;
  logic              w_handshake;
  logic              w_resp_comp;
  logic              w_push;
  logic              w_pop;
  logic              w_dec_valid;
  logic              w_drop;

  // The outstanding request owns a queue slot, so a response never needs a room check.
  assign w_count     = r_entries + CNT_W'(r_state == WAIT_RESP);
  assign w_req_valid = (r_state == IDLE) & bus.pc_req_i & (w_count < CNT_W'(DEPTH)) & ~bus.flush_i;
  assign w_handshake = w_req_valid & bus.icache_req_ready_i;
  assign w_resp_comp = bus.icache_resp_data_i[1:0] != 2'b11;
  assign w_push      = (r_state == WAIT_RESP) & bus.icache_resp_valid_i & ~bus.flush_i;
  assign w_dec_valid = r_entries != '0;
  assign w_pop       = w_dec_valid & bus.dec_ready_i & ~bus.flush_i;
  assign w_drop      = bus.icache_resp_valid_i &
                       (((r_state == WAIT_RESP) & bus.flush_i) | (r_state == DROP));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:      if (w_handshake) w_next_state = WAIT_RESP;
      WAIT_RESP: begin
        if (bus.icache_resp_valid_i) w_next_state = IDLE;
        else if (bus.flush_i)        w_next_state = DROP;
      end
      DROP:      if (bus.icache_resp_valid_i) w_next_state = IDLE;
      default:   w_next_state = IDLE;
    endcase
  end

  assign bus.icache_req_valid_o = w_req_valid;
  assign bus.icache_req_addr_o  = bus.pc_i;
  assign bus.fetch_stall_o      = ~(w_push | bus.flush_i);
  assign bus.is_compressed_o    = (r_state == WAIT_RESP) & bus.icache_resp_valid_i & w_resp_comp;
  assign bus.dec_valid_o        = w_dec_valid;
  assign bus.dec_inst_o         = w_dec_valid ? r_inst[r_rd_ptr] : '0;
  assign bus.dec_pc_o           = w_dec_valid ? r_pc[r_rd_ptr]   : '0;
  assign bus.dec_compressed_o   = w_dec_valid & r_comp[r_rd_ptr];

  // Flush wins over any same-cycle pop; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_entries <= '0;
    end else if (bus.flush_i) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_entries <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_entries <= r_entries + CNT_W'(1);
        2'b01:   r_entries <= r_entries - CNT_W'(1);
        default: r_entries <= r_entries;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_inst[r_wr_ptr] <= bus.icache_resp_data_i;
      r_pc[r_wr_ptr]   <= bus.pc_i;
      r_comp[r_wr_ptr] <= w_resp_comp;
    end
  end

`ifdef IFU_PERF_CNT_EN
  logic [63:0] r_fetch_cnt;
  logic [63:0] r_drop_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetch_cnt <= '0;
      r_drop_cnt  <= '0;
    end else begin
      if (w_push) r_fetch_cnt <= r_fetch_cnt + 64'd1;
      if (w_drop) r_drop_cnt  <= r_drop_cnt + 64'd1;
    end
  end

  assign bus.perf_fetch_cnt_o = r_fetch_cnt;
  assign bus.perf_drop_cnt_o  = r_drop_cnt;
`else
  logic w_unused_drop;
  assign w_unused_drop = w_drop;
`endif
endmodule

// File: tb/tb_ifu_fetch_queue.sv
// Bench for ifu_fetch_queue: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_ifu_fetch_queue;
  localparam int PC_W   = 32;
  localparam int INST_W = 32;
  localparam int DEPTH  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ifu_fetch_queue_if #(.PC_W(PC_W), .INST_W(INST_W)) bus ();

  ifu_fetch_queue #(.PC_W(PC_W), .INST_W(INST_W), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        comp;
  } entry_t;

  entry_t          modelQ[$];
  bit              modelWait;
  bit              modelDrop;
  logic [31:0]     pcReg;
  longint unsigned modelFetchCnt;
  longint unsigned modelDropCnt;
  int              testsRun;
  int              testsFailed;
  int              handshakes;
  logic            sStall, sComp, sReqValid, sDecValid, sDecComp;
  logic [31:0]     sAddr, sDecPc, sDecInst;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, expected);
    end
  endtask

  task automatic resetModel();
    modelQ.delete();
    modelWait     = 0;
    modelDrop     = 0;
    modelFetchCnt = 0;
    modelDropCnt  = 0;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_stall"},    bus.fetch_stall_o, 1);
    checkOutput({tag, "_reqvalid"}, bus.icache_req_valid_o, 0);
    checkOutput({tag, "_decvalid"}, bus.dec_valid_o, 0);
    checkOutput({tag, "_iscomp"},   bus.is_compressed_o, 0);
    checkOutput({tag, "_decinst"},  bus.dec_inst_o, 0);
    checkOutput({tag, "_decpc"},    bus.dec_pc_o, 0);
    checkOutput({tag, "_deccomp"},  bus.dec_compressed_o, 0);
`ifdef IFU_PERF_CNT_EN
    checkOutput({tag, "_perffetch"}, bus.perf_fetch_cnt_o, 0);
    checkOutput({tag, "_perfdrop"},  bus.perf_drop_cnt_o, 0);
`endif
  endtask

  // One cycle: drive inputs, compare against the model mid-cycle, then advance the model and PC.
  task automatic applyStimulus(input bit req, input bit flush, input logic [31:0] target,
                               input bit ready, input bit respV, input logic [31:0] data,
                               input bit decReady);
    bit     expReq, expPush, expComp, expDecValid;
    entry_t e;
    bus.pc_i                = pcReg;
    bus.pc_req_i            = req;
    bus.flush_i             = flush;
    bus.icache_req_ready_i  = ready;
    bus.icache_resp_valid_i = respV;
    bus.icache_resp_data_i  = data;
    bus.dec_ready_i         = decReady;
    @(negedge clk);
    expReq      = !modelWait && !modelDrop && req && (modelQ.size() < DEPTH) && !flush;
    expPush     = modelWait && respV && !flush;
    expComp     = modelWait && respV && (data[1:0] != 2'b11);
    expDecValid = modelQ.size() != 0;
    checkOutput("req_valid", bus.icache_req_valid_o, expReq);
    if (expReq) checkOutput("req_addr", bus.icache_req_addr_o, pcReg);
    checkOutput("fetch_stall", bus.fetch_stall_o, !(expPush || flush));
    checkOutput("is_compressed", bus.is_compressed_o, expComp);
    checkOutput("dec_valid", bus.dec_valid_o, expDecValid);
    if (expDecValid) begin
      checkOutput("dec_pc", bus.dec_pc_o, modelQ[0].pc);
      checkOutput("dec_inst", bus.dec_inst_o, modelQ[0].inst);
      checkOutput("dec_compressed", bus.dec_compressed_o, modelQ[0].comp);
    end
`ifdef IFU_PERF_CNT_EN
    checkOutput("perf_fetch", bus.perf_fetch_cnt_o, modelFetchCnt);
    checkOutput("perf_drop", bus.perf_drop_cnt_o, modelDropCnt);
`endif
    sStall    = bus.fetch_stall_o;
    sComp     = bus.is_compressed_o;
    sReqValid = bus.icache_req_valid_o;
    sAddr     = bus.icache_req_addr_o;
    sDecValid = bus.dec_valid_o;
    sDecPc    = bus.dec_pc_o;
    sDecInst  = bus.dec_inst_o;
    sDecComp  = bus.dec_compressed_o;
    if (expReq && ready) handshakes++;

    if (modelWait && respV) begin
      modelWait = 0;
      if (flush) modelDropCnt++;
    end else if (modelWait && flush) begin
      modelWait = 0;
      modelDrop = 1;
    end else if (modelDrop && respV) begin
      modelDrop = 0;
      modelDropCnt++;
    end else if (expReq && ready) begin
      modelWait = 1;
    end

    if (flush) modelQ.delete();
    else begin
      if (expDecValid && decReady) void'(modelQ.pop_front());
      if (expPush) begin
        e.pc   = pcReg;
        e.inst = data;
        e.comp = data[1:0] != 2'b11;
        modelQ.push_back(e);
        modelFetchCnt++;
      end
    end

    if (flush)        pcReg = target;
    else if (expPush) pcReg = pcReg + (expComp ? 32'd2 : 32'd4);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] randInst();
    logic [31:0] d;
    d = $urandom;
    if ($urandom_range(0, 1) == 1) d[1:0] = 2'b11;
    else d[1:0] = 2'($urandom_range(0, 2));
    return d;
  endfunction

  function automatic logic [31:0] randFull();
    logic [31:0] d;
    d = $urandom;
    d[1:0] = 2'b11;
    return d;
  endfunction

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] streamData [10];
    logic [31:0] t;
    bus.pc_i = '0; bus.pc_req_i = 0; bus.flush_i = 0; bus.icache_req_ready_i = 0;
    bus.icache_resp_valid_i = 0; bus.icache_resp_data_i = '0; bus.dec_ready_i = 0;
    testsRun = 0; testsFailed = 0; handshakes = 0;
    resetModel();
    pcReg = 32'h8000_0000;
    repeat (2) @(posedge clk);
    #1;
    checkResetValues("reset");
    rst = 1'b0;

    // Sequential 32-bit fetch followed by a compressed one.
    applyStimulus(1, 0, 0, 1, 0, 0, 0);
    checkOutput("seq_reqvalid", sReqValid, 1);
    checkOutput("seq_addr", sAddr, 32'h8000_0000);
    applyStimulus(0, 0, 0, 0, 1, 32'h0000_0513, 0);
    checkOutput("seq_stall", sStall, 0);
    checkOutput("seq_iscomp", sComp, 0);
    applyStimulus(1, 0, 0, 1, 0, 0, 1);
    checkOutput("seq_decvalid", sDecValid, 1);
    checkOutput("seq_decpc", sDecPc, 32'h8000_0000);
    checkOutput("seq_decinst", sDecInst, 32'h0000_0513);
    checkOutput("seq_deccomp", sDecComp, 0);
    checkOutput("seq_next_addr", sAddr, 32'h8000_0004);
    applyStimulus(0, 0, 0, 0, 1, 32'h0000_4501, 0);
    checkOutput("cmp_iscomp", sComp, 1);
    checkOutput("cmp_stall", sStall, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("cmp_decpc", sDecPc, 32'h8000_0004);
    checkOutput("cmp_deccomp", sDecComp, 1);
    checkOutput("cmp_stall_after", sStall, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 1);

    // Fill the queue with decode blocked: only DEPTH requests may issue.
    handshakes = 0;
    for (int i = 0; i < 16; i++) applyStimulus(1, 0, 0, 1, modelWait, randFull(), 0);
    checkOutput("full_issue_count", 64'(handshakes), DEPTH);
    checkOutput("full_blocked", sReqValid, 0);
    applyStimulus(1, 0, 0, 1, 0, 0, 1);
    checkOutput("full_blocked_popcycle", sReqValid, 0);
    applyStimulus(1, 0, 0, 1, 0, 0, 0);
    checkOutput("full_reopen", sReqValid, 1);
    applyStimulus(0, 0, 0, 0, 1, randFull(), 0);
    for (int i = 0; i < 6; i++) applyStimulus(0, 0, 0, 0, 0, 0, 1);

    // Flush while a request is outstanding: the late response must be dropped.
    applyStimulus(0, 1, 32'h8000_0010, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 1, 0, 0, 0);
    checkOutput("fl_addr", sAddr, 32'h8000_0010);
    applyStimulus(1, 1, 32'h8000_0100, 1, 0, 0, 0);
    checkOutput("fl_stall", sStall, 0);
    checkOutput("fl_reqvalid", sReqValid, 0);
    applyStimulus(1, 0, 0, 1, 1, 32'h0010_0093, 0);
    checkOutput("drop_reqvalid", sReqValid, 0);
    checkOutput("drop_stall", sStall, 1);
    applyStimulus(1, 0, 0, 1, 0, 0, 0);
    checkOutput("drop_next_reqvalid", sReqValid, 1);
    checkOutput("drop_next_addr", sAddr, 32'h8000_0100);
    checkOutput("drop_decvalid", sDecValid, 0);
    applyStimulus(0, 0, 0, 0, 1, randFull(), 1);

    // Flush coincident with the response returns straight to issuing.
    applyStimulus(1, 0, 0, 1, 0, 0, 1);
    applyStimulus(0, 1, 32'h8000_0200, 0, 1, 32'h0000_0013, 0);
    checkOutput("cf_stall", sStall, 0);
    applyStimulus(1, 0, 0, 1, 0, 0, 0);
    checkOutput("cf_reqvalid", sReqValid, 1);
    checkOutput("cf_addr", sAddr, 32'h8000_0200);
    checkOutput("cf_decvalid", sDecValid, 0);
    applyStimulus(0, 0, 0, 0, 1, randInst(), 0);

    // Two entries held while streaming push+pop through several pointer wraps.
    applyStimulus(1, 0, 0, 1, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, randInst(), 0);
    for (int i = 0; i < 10; i++) begin
      streamData[i] = randInst();
      applyStimulus(1, 0, 0, 1, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 1, streamData[i], 1);
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    checkOutput("stream_head0", sDecInst, streamData[8]);
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    checkOutput("stream_head1", sDecInst, streamData[9]);

    // Randomized traffic; the icache only answers while a request is outstanding or being dropped.
    for (int i = 0; i < 3000; i++) begin
      t = $urandom;
      t[0] = 1'b0;
      applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0, t,
                    $urandom_range(0, 1) == 1,
                    (modelWait || modelDrop) && ($urandom_range(0, 2) == 0),
                    randInst(), $urandom_range(0, 1) == 1);
    end

    // Asynchronous reset in the middle of an outstanding request.
    for (int i = 0; i < 20 && !modelWait; i++) applyStimulus(1, 0, 0, 1, 0, 0, 1);
    checkOutput("rst_setup_wait", modelWait, 1);
    bus.pc_req_i = 0;
    bus.flush_i  = 0;
    bus.icache_resp_valid_i = 0;
    bus.dec_ready_i = 0;
    #2 rst = 1'b1;
    #1;
    checkResetValues("async_reset");
    resetModel();
    @(posedge clk);
    #1 rst = 1'b0;
    applyStimulus(0, 0, 0, 0, 1, 32'h1234_5677, 0);
    checkOutput("late_stall", sStall, 1);
    checkOutput("late_iscomp", sComp, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("late_decvalid", sDecValid, 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end
endmodule
